rx_triple_sampler: RTL and testbench

- Serial-receive front end that sits directly upstream of the 3-input majority voter.
- Synchronises the asynchronous rx line and oversamples it at 16x the baud rate.
- Captures three samples (ticks 7, 8, 9) at the centre of every bit of an 8N1 frame and presents them as x/y/z with a one-cycle valid strobe.
- The voter resolves x/y/z to the bit value; downstream logic assembles bytes using bit_kind/bit_idx.

---
 rtl/rx_triple_sampler.sv | 156 +++++++++++++++
 tb/tb_rx_triple_sampler.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rx_triple_sampler.sv
// rx_triple_sampler
//   Serial-receive front end for an 8N1-style UART line. It synchronises rx,
//   oversamples at 16x the baud rate and captures three samples around the
//   centre of every bit (ticks 7, 8 and 9). The samples go to a downstream
//   3-input majority voter. The voter turns them into a bit value. Downstream
//   logic uses bit_kind and bit_idx to assemble the bytes.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   rx           asynchronous serial line, idle high
//   x, y, z      samples from ticks 7, 8 and 9 of the current bit
//   samp_valid   one-cycle strobe: x/y/z/bit_kind/bit_idx are valid
//   bit_kind     00 start, 01 data, 10 stop
//   bit_idx      data bit index, LSB first; 0 for start and stop bits
//   busy         high whenever a frame is being tracked
//   false_start  one-cycle pulse when a start bit is rejected
module rx_triple_sampler #(
  parameter int TICK_DIV  = 651,
  parameter int DATA_BITS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       samp_valid,
  output logic [1:0] bit_kind,
  output logic [3:0] bit_idx,
  output logic       busy,
  output logic       false_start
);

  localparam int         DIV_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state, state_next;
  logic             rx_meta, rx_s, rx_s_d;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       tick_cnt;
  logic [3:0]       data_idx;
  logic             fall, tick, wrap, reject;

  assign fall = rx_s_d & ~rx_s;
  // The divider only runs outside IDLE. So the first tick comes TICK_DIV
  // clocks after the start edge is accepted.
  assign tick   = (state != IDLE) && (div_cnt == DIV_LAST);
  assign wrap   = tick && (tick_cnt == 4'd15);
  // A start bit that is high again at mid-bit was a glitch.
  assign reject = (state == START) && tick && (tick_cnt == 4'd8) && rx_s;
  assign busy   = (state != IDLE);

  // Two-flop synchroniser plus one delay stage for falling-edge detection.
  // The flops reset to the idle level so that reset cannot fake an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (fall) state_next = START;
      START: begin
        if (reject)    state_next = IDLE;
        else if (wrap) state_next = DATA;
      end
      DATA:  if (wrap && (data_idx == LAST_BIT)) state_next = STOP;
      // Return as soon as the stop sample is presented. This leaves half a
      // bit of margin to catch the next start edge.
      STOP:  if (samp_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Divider and tick counter. Both are cleared whenever the FSM is in IDLE
  // or is about to return there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      tick_cnt <= 4'd0;
    end else if ((state == IDLE) || (state_next == IDLE)) begin
      div_cnt  <= '0;
      tick_cnt <= 4'd0;
    end else if (tick) begin
      div_cnt  <= '0;
      tick_cnt <= tick_cnt + 4'd1;  // 15 wraps to 0 naturally
    end else begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_idx <= 4'd0;
    end else if (state != DATA) begin
      data_idx <= 4'd0;
    end else if (wrap && (data_idx != LAST_BIT)) begin
      data_idx <= data_idx + 4'd1;
    end
  end

  // Sample capture and output strobes. bit_kind and bit_idx are updated on
  // the same edge as z. They then stay constant until the next bit's z capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= 1'b1;
      y           <= 1'b1;
      z           <= 1'b1;
      samp_valid  <= 1'b0;
      bit_kind    <= 2'b00;
      bit_idx     <= 4'd0;
      false_start <= 1'b0;
    end else begin
      samp_valid  <= 1'b0;
      false_start <= reject;
      if (tick && (tick_cnt == 4'd7)) x <= rx_s;
      if (tick && (tick_cnt == 4'd8)) y <= rx_s;
      if (tick && (tick_cnt == 4'd9)) begin
        z          <= rx_s;
        samp_valid <= 1'b1;
        case (state)
          DATA:    bit_kind <= 2'b01;
          STOP:    bit_kind <= 2'b10;
          default: bit_kind <= 2'b00;
        endcase
        bit_idx <= (state == DATA) ? data_idx : 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_rx_triple_sampler.sv
// tb_rx_triple_sampler
//   Directed testbench for rx_triple_sampler with TICK_DIV=4, so one bit is
//   64 clocks. A monitor logs every samp_valid pulse and counts false_start
//   pulses. A single initial block drives rx frames and checks the logged
//   pulses against values worked out by hand.
module tb_rx_triple_sampler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       x, y, z, samp_valid, busy, false_start;
  logic [1:0] bit_kind;
  logic [3:0] bit_idx;

  int n_checks = 0;
  int n_fail   = 0;

  int         pulse_n = 0;
  int         fs_n    = 0;
  logic [1:0] p_kind [64];
  logic [3:0] p_idx  [64];
  logic [2:0] p_xyz  [64];

  rx_triple_sampler #(.TICK_DIV(4), .DATA_BITS(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .x           (x),
    .y           (y),
    .z           (z),
    .samp_valid  (samp_valid),
    .bit_kind    (bit_kind),
    .bit_idx     (bit_idx),
    .busy        (busy),
    .false_start (false_start)
  );

  always #5 clk = ~clk;

  // Log the outputs on the falling edge, away from the active clock edge.
  always @(negedge clk) begin
    if (samp_valid) begin
      if (pulse_n < 64) begin
        p_kind[pulse_n] = bit_kind;
        p_idx[pulse_n]  = bit_idx;
        p_xyz[pulse_n]  = {x, y, z};
      end
      pulse_n = pulse_n + 1;
    end
    if (false_start) fs_n = fs_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives a frame: start, data LSB first, stop. At frame bit glitch_fbit
  // rx is forced low for one clock, aligned to the tick-8 capture.
  // When abort_fbit is reached, the task returns 20 clocks into that bit.
  task automatic send_frame(input logic [7:0] data, input int glitch_fbit, input int abort_fbit);
    logic [9:0] bits;
    bits = {1'b1, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int j = 0; j < 64; j++) begin
        if (b == abort_fbit && j == 20) return;
        @(negedge clk);
        rx = (b == glitch_fbit && j == 36) ? 1'b0 : bits[b];
      end
    end
  endtask

  // Checks the ten logged pulses that start at base against the frame
  // expected for data. The pulse at glitch_pulse is expected to read 101.
  task automatic check_frame(input string tag, input int base, input logic [7:0] data,
                             input int glitch_pulse);
    logic [2:0] exp_xyz;
    logic [1:0] exp_kind;
    logic [3:0] exp_idx;
    for (int k = 0; k < 10; k++) begin
      if (k == 0) begin
        exp_kind = 2'b00; exp_idx = 4'd0; exp_xyz = 3'b000;
      end else if (k == 9) begin
        exp_kind = 2'b10; exp_idx = 4'd0; exp_xyz = 3'b111;
      end else begin
        exp_kind = 2'b01; exp_idx = 4'(k - 1); exp_xyz = {3{data[k-1]}};
      end
      if (k == glitch_pulse) exp_xyz = 3'b101;
      check($sformatf("%s kind[%0d]", tag, k), 32'(p_kind[base+k]), 32'(exp_kind));
      check($sformatf("%s idx[%0d]",  tag, k), 32'(p_idx[base+k]),  32'(exp_idx));
      check($sformatf("%s xyz[%0d]",  tag, k), 32'(p_xyz[base+k]),  32'(exp_xyz));
    end
  endtask

  initial begin
    int base;
    int fs_base;

    // Reset hold, then a long idle period.
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    check("rst busy",  32'(busy), 32'd0);
    check("rst valid", 32'(samp_valid), 32'd0);
    check("rst xyz",   32'({x, y, z}), 32'h7);
    check("rst kind",  32'(bit_kind), 32'd0);
    check("rst idx",   32'(bit_idx), 32'd0);
    check("rst fs",    32'(false_start), 32'd0);
    rst_n = 1'b1;
    repeat (500) @(negedge clk);
    check("idle busy",   32'(busy), 32'd0);
    check("idle pulses", 32'(pulse_n), 32'd0);
    check("idle fs",     32'(fs_n), 32'd0);
    check("idle xyz",    32'({x, y, z}), 32'h7);
    $display("step idle: pulses=%0d busy=%0b", pulse_n, busy);

    // Frame 0xA5.
    base = pulse_n;
    send_frame(8'hA5, -1, -1);
    repeat (2) @(negedge clk);
    check("a5 count", 32'(pulse_n - base), 32'd10);
    check_frame("a5", base, 8'hA5, -1);
    check("a5 busy after", 32'(busy), 32'd0);
    $display("step frame 0xA5: pulses=%0d", pulse_n - base);

    // A 20-clock low glitch on the idle line.
    base    = pulse_n;
    fs_base = fs_n;
    repeat (20) begin
      @(negedge clk);
      rx = 1'b0;
    end
    @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch fs",     32'(fs_n - fs_base), 32'd1);
    check("glitch pulses", 32'(pulse_n - base), 32'd0);
    check("glitch busy",   32'(busy), 32'd0);
    $display("step glitch: false_start=%0d pulses=%0d", fs_n - fs_base, pulse_n - base);

    // Frame 0xFF with a one-clock low pulse on the tick-8 sample of data bit 3.
    base = pulse_n;
    send_frame(8'hFF, 4, -1);
    repeat (2) @(negedge clk);
    check("ff glitch count", 32'(pulse_n - base), 32'd10);
    check_frame("ffg", base, 8'hFF, 4);
    $display("step frame 0xFF glitched: pulses=%0d", pulse_n - base);

    // Frames 0x00 and 0xFF back to back, with no idle gap.
    base = pulse_n;
    send_frame(8'h00, -1, -1);
    send_frame(8'hFF, -1, -1);
    repeat (2) @(negedge clk);
    check("b2b count", 32'(pulse_n - base), 32'd20);
    check_frame("b2b0", base, 8'h00, -1);
    check_frame("b2b1", base + 10, 8'hFF, -1);
    $display("step back-to-back: pulses=%0d", pulse_n - base);

    // Reset asserted during data bit 4 of a frame.
    base = pulse_n;
    send_frame(8'h3C, -1, 5);
    check("mid busy", 32'(busy), 32'd1);
    check("mid pulses", 32'(pulse_n - base), 32'd5);
    rst_n = 1'b0;
    #1;
    check("mrst busy",  32'(busy), 32'd0);
    check("mrst valid", 32'(samp_valid), 32'd0);
    check("mrst xyz",   32'({x, y, z}), 32'h7);
    check("mrst kind",  32'(bit_kind), 32'd0);
    check("mrst idx",   32'(bit_idx), 32'd0);
    check("mrst fs",    32'(false_start), 32'd0);
    rx = 1'b1;
    base    = pulse_n;
    fs_base = fs_n;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check("post rst pulses", 32'(pulse_n - base), 32'd0);
    check("post rst fs",     32'(fs_n - fs_base), 32'd0);
    check("post rst busy",   32'(busy), 32'd0);
    $display("step mid-frame reset: pulses after=%0d", pulse_n - base);

    // A fresh frame is received after the reset.
    base = pulse_n;
    send_frame(8'h5A, -1, -1);
    repeat (2) @(negedge clk);
    check("5a count", 32'(pulse_n - base), 32'd10);
    check_frame("5a", base, 8'h5A, -1);
    $display("step frame 0x5A: pulses=%0d", pulse_n - base);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
